line_buffer: RTL and testbench

- Downstream consumer of the keyboard scan-to-ASCII stage.
- Collects printable characters into a one-line edit buffer and applies backspace and tab editing.
- On enter, commits the line and streams it out byte-by-byte over a valid/ready handshake to the text or display consumer.
- Gives the design a line-oriented input path.

---
 rtl/line_pkg.sv | 15 +
 rtl/line_mem.sv | 23 ++
 rtl/line_buffer.sv | 166 ++++++++++++++++
 tb/tb_line_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and character constants for the line-oriented keyboard input path.
package line_pkg;

  typedef enum logic [1:0] {
    EDIT     = 2'd0,
    TAB_FILL = 2'd1,
    DRAIN    = 2'd2
  } line_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_BS    = 8'h08;

endpackage

// File: rtl/line_mem.sv
// DEPTH x 8 line storage: one synchronous write port, one combinational read port,
// shaped so synthesis can map it onto distributed RAM.
module line_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/line_buffer.sv
// One-line edit buffer with backspace/tab editing; on enter the committed line is
// streamed out over a valid/ready handshake.
module line_buffer
  import line_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int TAB_WIDTH = 4,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    char_in,
  input  logic          enter,
  input  logic          tab,
  input  logic          backspace,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic [LW-1:0] len,
  output logic          busy,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW:0]   DEPTH_X = (LW + 1)'(DEPTH);
  localparam logic [LW:0]   TW_X    = (LW + 1)'(TAB_WIDTH);
  localparam logic [LW:0]   TW_MASK = ~((LW + 1)'(TAB_WIDTH - 1));

  line_state_t   state_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] ptr_reg;
  logic [LW-1:0] target_reg;
  logic          rd_valid_reg;
  logic [7:0]    rd_data_reg;
  logic          rd_last_reg;
  logic          busy_reg;
  logic          ovf_reg;

  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata;
  logic [LW-1:0] ptr_inc;
  logic [LW:0]   tab_up;
  logic          key_any;
  logic          xfer;

  assign key_any = (char_in != 8'h00) | enter | tab | backspace;
  assign xfer    = rd_valid_reg & rd_ready;
  assign ptr_inc = ptr_reg + ONE_L;
  // Next tab stop strictly above len; TAB_WIDTH is a power of two so masking rounds down.
  assign tab_up  = ({1'b0, len_reg} & TW_MASK) + TW_X;

  // The read port pre-fetches the byte that will be presented after the current edge.
  assign mem_raddr = (state_reg == DRAIN) ? ptr_inc[AW-1:0] : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = char_in;
    if (state_reg == EDIT && !enter && !backspace && !tab &&
        char_in != 8'h00 && len_reg < DEPTH_L) begin
      mem_we = 1'b1;
    end
    if (state_reg == TAB_FILL) begin
      mem_we    = 1'b1;
      mem_wdata = ASCII_SPACE;
    end
  end

  line_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (len_reg[AW-1:0]),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EDIT;
      len_reg      <= '0;
      ptr_reg      <= '0;
      target_reg   <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= 8'h00;
      rd_last_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        EDIT: begin
          if (enter) begin
            if (len_reg != '0) begin
              state_reg    <= DRAIN;
              ptr_reg      <= '0;
              rd_valid_reg <= 1'b1;
              rd_data_reg  <= mem_rdata;
              rd_last_reg  <= (len_reg == ONE_L);
              busy_reg     <= 1'b1;
            end
          end else if (backspace) begin
            if (len_reg != '0) len_reg <= len_reg - ONE_L;
          end else if (tab) begin
            if (len_reg == DEPTH_L) begin
              ovf_reg <= 1'b1;
            end else begin
              state_reg <= TAB_FILL;
              busy_reg  <= 1'b1;
              if (tab_up > DEPTH_X) begin
                ovf_reg    <= 1'b1;
                target_reg <= DEPTH_L;
              end else begin
                target_reg <= tab_up[LW-1:0];
              end
            end
          end else if (char_in != 8'h00) begin
            if (len_reg < DEPTH_L) len_reg <= len_reg + ONE_L;
            else                   ovf_reg <= 1'b1;
          end
        end

        TAB_FILL: begin
          len_reg <= len_reg + ONE_L;
          if (len_reg + ONE_L == target_reg) begin
            state_reg <= EDIT;
            busy_reg  <= 1'b0;
          end
          if (key_any) ovf_reg <= 1'b1;
        end

        DRAIN: begin
          if (key_any) ovf_reg <= 1'b1;
          if (xfer) begin
            if (rd_last_reg) begin
              // Final byte: the line is done, and the clear wins over a same-cycle drop.
              state_reg    <= EDIT;
              rd_valid_reg <= 1'b0;
              rd_last_reg  <= 1'b0;
              len_reg      <= '0;
              ovf_reg      <= 1'b0;
              busy_reg     <= 1'b0;
            end else begin
              ptr_reg     <= ptr_inc;
              rd_data_reg <= mem_rdata;
              rd_last_reg <= (ptr_inc == len_reg - ONE_L);
            end
          end
        end

        default: state_reg <= EDIT;
      endcase
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_last  = rd_last_reg;
  assign len      = len_reg;
  assign busy     = busy_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_line_buffer.sv
// Directed and randomized bench for line_buffer; the reference is a byte queue
// holding the current line plus a sticky overflow flag.
module tb_line_buffer;

  localparam int DEPTH = 32;
  localparam int TW    = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    char_in = 8'h00;
  logic          enter = 1'b0;
  logic          tab = 1'b0;
  logic          backspace = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_last;
  logic [LW-1:0] len;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  byte unsigned line_q[$];
  bit           ovf_m = 1'b0;

  always #5 clk = ~clk;

  line_buffer #(.DEPTH(DEPTH), .TAB_WIDTH(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_in   (char_in),
    .enter     (enter),
    .tab       (tab),
    .backspace (backspace),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .len       (len),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [7:0] c);
    char_in = c;
    @(negedge clk);
    char_in = 8'h00;
    if (line_q.size() < DEPTH) line_q.push_back(c);
    else                       ovf_m = 1'b1;
    chk("key_len", 32'(len), line_q.size());
    chk("key_ovf", 32'(overflow), 32'(ovf_m));
    $display("key %02h len=%0d ovf=%0d", c, len, overflow);
  endtask

  task automatic bs();
    backspace = 1'b1;
    @(negedge clk);
    backspace = 1'b0;
    if (line_q.size() > 0) void'(line_q.pop_back());
    chk("bs_len", 32'(len), line_q.size());
    $display("backspace len=%0d", len);
  endtask

  task automatic do_tab();
    int t;
    int fill;
    int n;
    tab = 1'b1;
    @(negedge clk);
    tab = 1'b0;
    if (line_q.size() == DEPTH) begin
      ovf_m = 1'b1;
      t = DEPTH;
    end else begin
      t = (line_q.size() / TW + 1) * TW;
      if (t > DEPTH) begin
        t = DEPTH;
        ovf_m = 1'b1;
      end
    end
    fill = t - line_q.size();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tab_busy_cycles", n, fill);
    while (line_q.size() < t) line_q.push_back(8'h20);
    chk("tab_len", 32'(len), line_q.size());
    chk("tab_ovf", 32'(overflow), 32'(ovf_m));
    $display("tab fill=%0d len=%0d", n, len);
  endtask

  // ready_mode: 0 always ready, 1 random ready, 2 stall for the first 5 cycles.
  task automatic drain(input int ready_mode, input bit noise);
    int  idx;
    int  cyc;
    bit  rdy;
    bit  kp;
    idx = 0;
    cyc = 0;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    if (line_q.size() == 0) begin
      chk("enter_empty_valid", 32'(rd_valid), 0);
      chk("enter_empty_busy", 32'(busy), 0);
      $display("enter on empty line ignored");
      return;
    end
    chk("enter_latency", 32'(rd_valid), 1);
    while (idx < line_q.size() && cyc < 2000) begin
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(line_q[idx]));
      chk("drain_last", 32'(rd_last), 32'(idx == line_q.size() - 1));
      chk("drain_ovf", 32'(overflow), 32'(ovf_m));
      chk("drain_busy", 32'(busy), 1);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 5);
      endcase
      if (!noise)                          kp = 1'b0;
      else if (ready_mode == 2 && cyc < 5) kp = 1'b1;
      else                                 kp = 1'($urandom_range(0, 1));
      rd_ready = rdy;
      char_in  = kp ? 8'h41 : 8'h00;
      @(negedge clk);
      rd_ready = 1'b0;
      char_in  = 8'h00;
      cyc++;
      if (rdy) begin
        $display("xfer byte %0d data=%02h", idx, line_q[idx]);
        idx++;
      end
      if (kp && !(rdy && idx == line_q.size())) ovf_m = 1'b1;
    end
    chk("drain_done", idx, line_q.size());
    line_q.delete();
    ovf_m = 1'b0;
    chk("post_valid", 32'(rd_valid), 0);
    chk("post_last", 32'(rd_last), 0);
    chk("post_len", 32'(len), 0);
    chk("post_ovf", 32'(overflow), 0);
    chk("post_busy", 32'(busy), 0);
    $display("line drained in %0d cycles", cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    int         nops;
    int         op;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_last", 32'(rd_last), 0);
    chk("rst_len", 32'(len), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    drain(0, 1'b0);

    key(8'h48); key(8'h69);
    drain(0, 1'b0);

    key(8'h61); key(8'h62); key(8'h63); bs(); key(8'h64);
    chk("abd_len", 32'(len), 3);
    drain(0, 1'b0);

    key(8'h78); do_tab(); key(8'h79);
    drain(0, 1'b0);

    bs();
    for (int i = 0; i < 33; i++) key(8'($urandom_range(8'h21, 8'h7E)));
    chk("full_len", 32'(len), 32);
    chk("full_ovf", 32'(overflow), 1);
    do_tab();
    drain(0, 1'b0);

    key(8'h31); key(8'h32); key(8'h33);
    drain(2, 1'b1);

    for (int l = 0; l < 6; l++) begin
      nops = $urandom_range(1, 40);
      for (int k = 0; k < nops; k++) begin
        op = $urandom_range(0, 9);
        if (op == 0)      bs();
        else if (op == 1) do_tab();
        else begin
          c = 8'($urandom_range(8'h21, 8'h7E));
          key(c);
        end
      end
      drain(1, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a drain abandons the line
    key(8'h70); key(8'h71); key(8'h72);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    rd_ready = 1'b1;
    char_in  = 8'h41;
    @(negedge clk);
    rd_ready = 1'b0;
    char_in  = 8'h00;
    chk("middrain_ovf", 32'(overflow), 1);
    chk("middrain_valid", 32'(rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_len", 32'(len), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_busy", 32'(busy), 0);
    $display("async reset mid-drain");
    @(negedge clk);
    rst_n = 1'b1;
    line_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    key(8'h7A);
    drain(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
